paddle_controller: RTL and testbench
====================================

Name: paddle_controller

Overview:
Converts the player's raw active-low push-buttons (left, right, pause) into paddle motion and pause state for the Breakout game core. Single press gives one step. Holding a direction auto-repeats after an initial delay. Positions are clamped to the playfield. Sits between the board buttons and the ball/paddle collision and render logic.

Parameters:
SCREEN_W, 640, playfield width in pixels
PADDLE_W, 80, paddle width in pixels
STEP, 8, pixels moved per step
HOLD_DELAY, 12500000, cycles from first step to first auto-repeat step (0.25 s at 50 MHz)
REPEAT_PERIOD, 1250000, cycles between auto-repeat steps
X_INIT, 280, paddle left-edge x after reset or new_game

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high
btn_left_n  in  1  raw left button, active-low, asynchronous to clock
btn_right_n  in  1  raw right button, active-low
btn_pause_n  in  1  raw pause button, active-low
game_over  in  1  level; freezes paddle and ignores pause while high
new_game  in  1  one-cycle pulse; recenters paddle, clears pause
paddle_x  out  10  paddle left-edge x, range 0..SCREEN_W-PADDLE_W
paused  out  1  pause state
step_l  out  1  one-cycle pulse when a left move is applied
step_r  out  1  one-cycle pulse when a right move is applied

Behaviour:
- Reset values: paddle_x=X_INIT, paused=0, step_l=0, step_r=0. Synchronizer flops reset to 1 (released). All FSMs go to IDLE and all counters to 0.
- Each raw button passes through a 2-flop synchronizer. Only synchronized levels are used.
- Per-direction repeat FSM, with states IDLE, FIRST, DELAY, REPEAT:
  - IDLE goes to FIRST when the synchronized level is low.
  - FIRST lasts one cycle and asserts the internal request. It then goes to DELAY with the counter cleared.
  - DELAY counts to HOLD_DELAY-1, then asserts the request for one cycle and goes to REPEAT with the counter cleared.
  - REPEAT asserts the request every REPEAT_PERIOD cycles.
  - From any non-IDLE state, a synchronized high level goes to IDLE next cycle with no request.
- Pause uses an edge-only FSM with states IDLE, PRESSED, HELD. There is no repeat: one request per press, and re-arming requires release.
- Latency:
  - Raw low sampled at edge k gives a request during cycle k+2..k+3.
  - paddle_x, step_l/step_r (registered) and paused update at edge k+3.
  - So the output change is visible 3 cycles after the raw input falls.
- Move arithmetic is computed 11 bits wide.
  - Left: x >= STEP ? x-STEP : 0.
  - Right: x+STEP <= SCREEN_W-PADDLE_W ? x+STEP : SCREEN_W-PADDLE_W.
  - step_l/step_r pulse only when a move is applied, including a clamped move. No pulse when the paddle is already at the limit.
- Same-cycle priority, highest first:
  1. reset
  2. new_game (paddle_x=X_INIT, paused=0, all requests discarded)
  3. game_over (move and pause requests discarded)
  4. pause request (toggles paused)
  5. moves. These are discarded while paused=1 or if a pause toggle happens in the same cycle.
- Left and right requests in the same cycle cancel each other: no move, no pulse.
- Repeat FSMs keep running while paused or game_over. Requests are simply dropped.
- Reset mid-hold: FSM returns to IDLE. If the button is still held, a new FIRST step fires 3 cycles after reset deasserts.

Decomposition:
- Shared package breakout_pkg holds:
  - the FSM state typedef (IDLE, FIRST, DELAY, REPEAT);
  - the playfield constants SCREEN_W and PADDLE_W, shared with the render and collision logic.
- One sub-module, key_repeat, with parameters HOLD_DELAY, REPEAT_PERIOD and REPEAT_EN.
  - It contains the synchronizer, the FSM and the counter.
  - Instantiated 3 times: pause with REPEAT_EN=0.

Test Plan:
Bench parameters: SCREEN_W=64, PADDLE_W=16, STEP=4, HOLD_DELAY=8, REPEAT_PERIOD=4, X_INIT=24.
1. Reset, then hold btn_left_n low 5 cycles -> paddle_x 24->20 exactly 3 cycles after the fall; one step_l pulse; no further change.
2. Hold btn_right_n low 40 cycles -> step_r pulses at t0, t0+8, t0+12, t0+16, t0+20, t0+24; paddle_x 28, 32, 36, 40, 44, 48, then stays at 48 with no further step_r pulses.
3. X_INIT=2 override, one left press -> paddle_x=0 and step_l pulses; a second press -> paddle_x stays 0, no step_l.
4. btn_left_n and btn_right_n fall on the same edge, held 3 cycles -> paddle_x stays 24, no step pulses.
5. Pause held 20 cycles -> paused=1 once, with no re-toggle. Right press while paused -> paddle_x unchanged. Second pause press -> paused=0. Next right press -> 28.
6. Hold right into REPEAT, pulse new_game -> paddle_x=24, paused=0. Then assert reset mid-hold -> IDLE; with the button still low, first step arrives 3 cycles after reset falls (x=28).

Source files
------------

// File: rtl/breakout_pkg.sv
// Shared Breakout definitions: key FSM states and playfield geometry.
// Latency: none (types and constants only).
// Backpressure: none.
package breakout_pkg;

  // Per-button key FSM; for edge-only keys DELAY doubles as the HELD state
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FIRST  = 2'd1,
    DELAY  = 2'd2,
    REPEAT = 2'd3
  } key_state_t;

  // Playfield geometry shared with render and collision logic
  localparam int SCREEN_W = 640;
  localparam int PADDLE_W = 80;

endpackage

// File: rtl/paddle_controller_key_repeat.sv
// Synchronizes one active-low button and turns presses into one-cycle requests, optionally auto-repeating.
// Latency: raw low sampled at edge k gives o_req during cycle k+2..k+3 (combinational from state).
// Backpressure: none; requests are fire-and-forget and the consumer may drop them.
module key_repeat
  import breakout_pkg::*;
#(
  parameter int HOLD_DELAY    = 12500000,
  parameter int REPEAT_PERIOD = 1250000,
  parameter bit REPEAT_EN     = 1'b1
) (
  input  logic clock,
  input  logic reset,
  input  logic i_btn_n,
  output logic o_req
);

  localparam int CNT_MAX = (HOLD_DELAY > REPEAT_PERIOD) ? HOLD_DELAY : REPEAT_PERIOD;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] DELAY_LAST  = CW'(HOLD_DELAY - 1);
  localparam logic [CW-1:0] REPEAT_LAST = CW'(REPEAT_PERIOD - 1);

  logic          r_sync1;
  logic          r_sync2;
  key_state_t    r_state;
  logic [CW-1:0] r_cnt;

  // Two-flop synchronizer; resets to the released (high) level
  always_ff @(posedge clock) begin
    if (reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= i_btn_n;
      r_sync2 <= r_sync1;
    end
  end

  // Press / hold-delay / repeat state machine with its shared cycle counter
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else if (r_sync2) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_state <= FIRST;
          r_cnt   <= '0;
        end
        FIRST: begin
          r_state <= DELAY;
          r_cnt   <= '0;
        end
        DELAY: begin
          // Edge-only keys park here until release
          if (REPEAT_EN) begin
            if (r_cnt == DELAY_LAST) begin
              r_state <= REPEAT;
              r_cnt   <= '0;
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end
        end
        REPEAT: begin
          if (r_cnt == REPEAT_LAST) begin
            r_cnt <= '0;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  // A released level suppresses the request even in a firing state
  assign o_req = !r_sync2 &&
                 ((r_state == FIRST) ||
                  (REPEAT_EN && (r_state == DELAY)  && (r_cnt == DELAY_LAST)) ||
                  (REPEAT_EN && (r_state == REPEAT) && (r_cnt == REPEAT_LAST)));

endmodule

// File: rtl/paddle_controller.sv
// Turns left/right/pause buttons into clamped paddle position, step pulses and pause state.
// Latency: output change at edge k+3 for a raw press first sampled at edge k.
// Backpressure: none; requests arriving while paused or game_over are dropped.
module paddle_controller #(
  parameter int SCREEN_W      = breakout_pkg::SCREEN_W,
  parameter int PADDLE_W      = breakout_pkg::PADDLE_W,
  parameter int STEP          = 8,
  parameter int HOLD_DELAY    = 12500000,
  parameter int REPEAT_PERIOD = 1250000,
  parameter int X_INIT        = 280
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       btn_left_n,
  input  logic       btn_right_n,
  input  logic       btn_pause_n,
  input  logic       game_over,
  input  logic       new_game,
  output logic [9:0] paddle_x,
  output logic       paused,
  output logic       step_l,
  output logic       step_r
);

  localparam logic [10:0] X_MAX11  = 11'(SCREEN_W - PADDLE_W);
  localparam logic [9:0]  X_MAX10  = 10'(SCREEN_W - PADDLE_W);
  localparam logic [10:0] STEP11   = 11'(STEP);
  localparam logic [9:0]  STEP10   = 10'(STEP);
  localparam logic [9:0]  X_INIT10 = 10'(X_INIT);

  logic        w_req_l;
  logic        w_req_r;
  logic        w_req_p;
  logic [10:0] w_x11;
  logic [10:0] w_right_sum;
  logic [9:0]  w_left_x;
  logic [9:0]  w_right_x;
  logic        w_can_l;
  logic        w_can_r;

  logic [9:0]  r_x;
  logic        r_paused;
  logic        r_step_l;
  logic        r_step_r;

  key_repeat #(
    .HOLD_DELAY   (HOLD_DELAY),
    .REPEAT_PERIOD(REPEAT_PERIOD),
    .REPEAT_EN    (1'b1)
  ) u_key_left (
    .clock  (clock),
    .reset  (reset),
    .i_btn_n(btn_left_n),
    .o_req  (w_req_l)
  );

  key_repeat #(
    .HOLD_DELAY   (HOLD_DELAY),
    .REPEAT_PERIOD(REPEAT_PERIOD),
    .REPEAT_EN    (1'b1)
  ) u_key_right (
    .clock  (clock),
    .reset  (reset),
    .i_btn_n(btn_right_n),
    .o_req  (w_req_r)
  );

  key_repeat #(
    .HOLD_DELAY   (HOLD_DELAY),
    .REPEAT_PERIOD(REPEAT_PERIOD),
    .REPEAT_EN    (1'b0)
  ) u_key_pause (
    .clock  (clock),
    .reset  (reset),
    .i_btn_n(btn_pause_n),
    .o_req  (w_req_p)
  );

  // Move arithmetic is 11 bits wide so the right-side sum cannot wrap
  assign w_x11       = {1'b0, r_x};
  assign w_right_sum = w_x11 + STEP11;
  assign w_left_x    = (w_x11 >= STEP11) ? (r_x - STEP10) : 10'd0;
  assign w_right_x   = (w_right_sum <= X_MAX11) ? w_right_sum[9:0] : X_MAX10;
  // A move only counts (and pulses) when the paddle is not already at that wall
  assign w_can_l     = (r_x != 10'd0);
  assign w_can_r     = (w_x11 < X_MAX11);

  // Priority: new_game, game_over, pause toggle, then moves (opposing moves cancel)
  always_ff @(posedge clock) begin
    if (reset) begin
      r_x      <= X_INIT10;
      r_paused <= 1'b0;
      r_step_l <= 1'b0;
      r_step_r <= 1'b0;
    end else begin
      r_step_l <= 1'b0;
      r_step_r <= 1'b0;
      if (new_game) begin
        r_x      <= X_INIT10;
        r_paused <= 1'b0;
      end else if (!game_over) begin
        if (w_req_p) begin
          r_paused <= !r_paused;
        end else if (!r_paused && (w_req_l != w_req_r)) begin
          if (w_req_l && w_can_l) begin
            r_x      <= w_left_x;
            r_step_l <= 1'b1;
          end
          if (w_req_r && w_can_r) begin
            r_x      <= w_right_x;
            r_step_r <= 1'b1;
          end
        end
      end
    end
  end

  assign paddle_x = r_x;
  assign paused   = r_paused;
  assign step_l   = r_step_l;
  assign step_r   = r_step_r;

endmodule

// File: tb/tb_paddle_controller.sv
// Bench for paddle_controller: directed scenarios plus randomized run against a run-length reference model.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: none.
module tb_paddle_controller;

  localparam int SW   = 64;
  localparam int PW   = 16;
  localparam int ST   = 4;
  localparam int HD   = 8;
  localparam int RP   = 4;
  localparam int XI   = 24;
  localparam int XMAX = SW - PW;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       btn_left_n = 1'b1;
  logic       btn_right_n = 1'b1;
  logic       btn_pause_n = 1'b1;
  logic       game_over = 1'b0;
  logic       new_game = 1'b0;
  logic [9:0] paddle_x, paddle_x2;
  logic       paused, paused2;
  logic       step_l, step_l2, step_r, step_r2;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  paddle_controller #(.SCREEN_W(SW), .PADDLE_W(PW), .STEP(ST), .HOLD_DELAY(HD),
                      .REPEAT_PERIOD(RP), .X_INIT(XI)) dut (
    .clock(clock), .reset(reset), .btn_left_n(btn_left_n), .btn_right_n(btn_right_n),
    .btn_pause_n(btn_pause_n), .game_over(game_over), .new_game(new_game),
    .paddle_x(paddle_x), .paused(paused), .step_l(step_l), .step_r(step_r));

  paddle_controller #(.SCREEN_W(SW), .PADDLE_W(PW), .STEP(ST), .HOLD_DELAY(HD),
                      .REPEAT_PERIOD(RP), .X_INIT(2)) dut2 (
    .clock(clock), .reset(reset), .btn_left_n(btn_left_n), .btn_right_n(btn_right_n),
    .btn_pause_n(btn_pause_n), .game_over(game_over), .new_game(new_game),
    .paddle_x(paddle_x2), .paused(paused2), .step_l(step_l2), .step_r(step_r2));

  // ---------------- reference model ----------------
  // Each button is tracked by the length of its current low run. A request
  // lands at edge e when the run seen at edge e-2 has length >= 2: n = run-2
  // cycles into the hold, firing at n==0, and (repeat keys) at n==HD, HD+RP, ...
  int m_x;
  bit m_paused, m_sl, m_sr;
  int hl1, hl2, hr1, hr2, hp1, hp2;

  function automatic bit fires(int run, bit rep);
    int n;
    if (run < 2) return 1'b0;
    n = run - 2;
    if (n == 0) return 1'b1;
    if (!rep) return 1'b0;
    return (n >= HD) && (((n - HD) % RP) == 0);
  endfunction

  always @(posedge clock) begin
    bit rl, rr, rp;
    int nl, nr, np;
    if (reset) begin
      m_x = XI; m_paused = 0; m_sl = 0; m_sr = 0;
      hl1 = 0; hl2 = 0; hr1 = 0; hr2 = 0; hp1 = 0; hp2 = 0;
    end else begin
      rl = fires(hl2, 1'b1);
      rr = fires(hr2, 1'b1);
      rp = fires(hp2, 1'b0);
      m_sl = 0; m_sr = 0;
      if (new_game) begin
        m_x = XI; m_paused = 0;
      end else if (!game_over) begin
        if (rp) m_paused = !m_paused;
        else if (!m_paused && (rl != rr)) begin
          if (rl && m_x > 0) begin
            m_x = (m_x >= ST) ? m_x - ST : 0; m_sl = 1;
          end
          if (rr && m_x < XMAX) begin
            m_x = (m_x + ST <= XMAX) ? m_x + ST : XMAX; m_sr = 1;
          end
        end
      end
      nl = btn_left_n  ? 0 : hl1 + 1;
      nr = btn_right_n ? 0 : hr1 + 1;
      np = btn_pause_n ? 0 : hp1 + 1;
      hl2 = hl1; hl1 = nl;
      hr2 = hr1; hr1 = nr;
      hp2 = hp1; hp1 = np;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    btn_left_n = 1; btn_right_n = 1; btn_pause_n = 1;
    game_over = 0; new_game = 0;
    reset = 1;
    tick(); tick();
    reset = 0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    btn_left_n = 1; btn_right_n = 1; btn_pause_n = 1;
    reset = 1;
    tick(); tick();
    n_cmp++; if (paddle_x !== 10'd24) begin n_bad++; $display("FAIL reset_x got %0d want 24", paddle_x); end
    n_cmp++; if (paused !== 1'b0) begin n_bad++; $display("FAIL reset_paused got %b want 0", paused); end
    n_cmp++; if (step_l !== 1'b0 || step_r !== 1'b0) begin n_bad++; $display("FAIL reset_steps got %b%b want 00", step_l, step_r); end
    n_cmp++; if (paddle_x2 !== 10'd2) begin n_bad++; $display("FAIL reset_x2 got %0d want 2", paddle_x2); end
    reset = 0;
  endtask

  task automatic test_single_step();
    int ex;
    do_reset();
    btn_left_n = 0;
    for (int i = 1; i <= 15; i++) begin
      tick();
      if (i == 5) btn_left_n = 1;
      ex = (i >= 4) ? 20 : 24;
      n_cmp++; if (paddle_x !== 10'(ex)) begin n_bad++; $display("FAIL single_x tick %0d got %0d want %0d", i, paddle_x, ex); end
      n_cmp++; if (step_l !== (i == 4)) begin n_bad++; $display("FAIL single_step_l tick %0d got %b want %b", i, step_l, (i == 4)); end
      n_cmp++; if (step_r !== 1'b0) begin n_bad++; $display("FAIL single_step_r tick %0d got %b want 0", i, step_r); end
    end
  endtask

  task automatic test_auto_repeat();
    int exp_t[6] = '{4, 12, 16, 20, 24, 28};
    int ex;
    bit es;
    do_reset();
    btn_right_n = 0;
    for (int i = 1; i <= 50; i++) begin
      tick();
      if (i == 40) btn_right_n = 1;
      ex = XI; es = 0;
      for (int j = 0; j < 6; j++) begin
        if (i >= exp_t[j]) ex += ST;
        if (i == exp_t[j]) es = 1;
      end
      n_cmp++; if (paddle_x !== 10'(ex)) begin n_bad++; $display("FAIL repeat_x tick %0d got %0d want %0d", i, paddle_x, ex); end
      n_cmp++; if (step_r !== es) begin n_bad++; $display("FAIL repeat_step_r tick %0d got %b want %b", i, step_r, es); end
    end
  endtask

  task automatic test_clamp_low();
    do_reset();
    for (int p = 0; p < 2; p++) begin
      btn_left_n = 0;
      for (int i = 1; i <= 10; i++) begin
        tick();
        if (i == 4) btn_left_n = 1;
        n_cmp++;
        if (paddle_x2 !== ((p == 0 && i < 4) ? 10'd2 : 10'd0)) begin
          n_bad++; $display("FAIL clamp_x press %0d tick %0d got %0d", p, i, paddle_x2);
        end
        n_cmp++;
        if (step_l2 !== (p == 0 && i == 4)) begin
          n_bad++; $display("FAIL clamp_step_l press %0d tick %0d got %b want %b", p, i, step_l2, (p == 0 && i == 4));
        end
      end
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    btn_left_n = 0; btn_right_n = 0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (i == 3) begin btn_left_n = 1; btn_right_n = 1; end
      n_cmp++; if (paddle_x !== 10'd24) begin n_bad++; $display("FAIL simul_x tick %0d got %0d want 24", i, paddle_x); end
      n_cmp++; if (step_l !== 1'b0 || step_r !== 1'b0) begin n_bad++; $display("FAIL simul_steps tick %0d got %b%b want 00", i, step_l, step_r); end
    end
  endtask

  task automatic test_pause();
    do_reset();
    btn_pause_n = 0;
    for (int i = 1; i <= 26; i++) begin
      tick();
      if (i == 20) btn_pause_n = 1;
      n_cmp++; if (paused !== (i >= 4)) begin n_bad++; $display("FAIL pause_on tick %0d got %b want %b", i, paused, (i >= 4)); end
    end
    btn_right_n = 0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (i == 5) btn_right_n = 1;
      n_cmp++; if (paddle_x !== 10'd24 || step_r !== 1'b0) begin n_bad++; $display("FAIL pause_block tick %0d got x=%0d step_r=%b want x=24 step_r=0", i, paddle_x, step_r); end
    end
    btn_pause_n = 0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (i == 5) btn_pause_n = 1;
      n_cmp++; if (paused !== (i < 4)) begin n_bad++; $display("FAIL pause_off tick %0d got %b want %b", i, paused, (i < 4)); end
    end
    btn_right_n = 0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (i == 5) btn_right_n = 1;
      n_cmp++; if (paddle_x !== ((i >= 4) ? 10'd28 : 10'd24)) begin n_bad++; $display("FAIL pause_resume_x tick %0d got %0d want %0d", i, paddle_x, (i >= 4) ? 28 : 24); end
    end
  endtask

  task automatic test_new_game_reset();
    do_reset();
    btn_right_n = 0;
    for (int i = 1; i <= 31; i++) begin
      tick();
      case (i)
        12: begin
          n_cmp++; if (paddle_x !== 10'd32 || step_r !== 1'b1) begin n_bad++; $display("FAIL ng_pre12 got x=%0d step_r=%b want x=32 step_r=1", paddle_x, step_r); end
        end
        13: btn_pause_n = 0;
        16: begin
          n_cmp++; if (paddle_x !== 10'd36) begin n_bad++; $display("FAIL ng_pre16 got %0d want 36", paddle_x); end
        end
        17: begin
          n_cmp++; if (paused !== 1'b1) begin n_bad++; $display("FAIL ng_paused17 got %b want 1", paused); end
        end
        21: begin
          n_cmp++; if (paddle_x !== 10'd36 || paused !== 1'b1) begin n_bad++; $display("FAIL ng_hold21 got x=%0d p=%b want x=36 p=1", paddle_x, paused); end
          new_game = 1;
        end
        22: begin
          new_game = 0;
          btn_pause_n = 1;
          n_cmp++; if (paddle_x !== 10'd24 || paused !== 1'b0) begin n_bad++; $display("FAIL ng_apply got x=%0d p=%b want x=24 p=0", paddle_x, paused); end
        end
        24: begin
          n_cmp++; if (paddle_x !== 10'd28 || step_r !== 1'b1) begin n_bad++; $display("FAIL ng_after got x=%0d step_r=%b want x=28 step_r=1", paddle_x, step_r); end
        end
        25: reset = 1;
        27: begin
          n_cmp++; if (paddle_x !== 10'd24 || paused !== 1'b0 || step_r !== 1'b0) begin n_bad++; $display("FAIL rst_mid got x=%0d p=%b step_r=%b want 24/0/0", paddle_x, paused, step_r); end
          reset = 0;
        end
        28, 29, 30: begin
          n_cmp++; if (paddle_x !== 10'd24 || step_r !== 1'b0) begin n_bad++; $display("FAIL rst_wait tick %0d got x=%0d step_r=%b want 24/0", i, paddle_x, step_r); end
        end
        31: begin
          n_cmp++; if (paddle_x !== 10'd28 || step_r !== 1'b1) begin n_bad++; $display("FAIL rst_first got x=%0d step_r=%b want 28/1", paddle_x, step_r); end
        end
        default: ;
      endcase
    end
    btn_right_n = 1;
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 11) == 0) btn_left_n  = ~btn_left_n;
      if ($urandom_range(0, 11) == 0) btn_right_n = ~btn_right_n;
      if ($urandom_range(0, 19) == 0) btn_pause_n = ~btn_pause_n;
      if ($urandom_range(0, 63) == 0) game_over = ~game_over;
      new_game = ($urandom_range(0, 99) == 0);
      reset    = ($urandom_range(0, 299) == 0);
      tick();
      n_cmp++; if (paddle_x !== 10'(m_x)) begin n_bad++; $display("FAIL rand_x cyc %0d got %0d want %0d", i, paddle_x, m_x); end
      n_cmp++; if (paused !== m_paused) begin n_bad++; $display("FAIL rand_paused cyc %0d got %b want %b", i, paused, m_paused); end
      n_cmp++; if (step_l !== m_sl) begin n_bad++; $display("FAIL rand_step_l cyc %0d got %b want %b", i, step_l, m_sl); end
      n_cmp++; if (step_r !== m_sr) begin n_bad++; $display("FAIL rand_step_r cyc %0d got %b want %b", i, step_r, m_sr); end
    end
    reset = 0; new_game = 0; game_over = 0;
  endtask

  initial begin
    test_reset();
    test_single_step();
    test_auto_repeat();
    test_clamp_low();
    test_simultaneous();
    test_pause();
    test_new_game_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
